// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: one Moore FSM driving every datapath
// enable and mux select, with in-state branch resolution and a memory
// wait handshake (mem_ready).
//
// Ports:
//   i_clk, i_rst              clock (rising edge), async active-high reset
//   i_opcode/i_funct3/i_funct7_5  instruction fields from the IR
//   i_alu_zero/lt/ltu         ALU compare flags for branch resolution
//   i_mem_ready               memory completes its access this cycle
//   o_pc_write .. o_mem_read  datapath write/access enables
//   o_address_src             0=PC, 1=ALUOut
//   o_result_src              00=ALUOut, 01=mem data reg, 10=ALU result
//   o_alu_src_A               00=PC, 01=old_PC, 10=rs1, 11=zero
//   o_alu_src_B               00=rs2, 01=imm, 10=constant 4
//   o_imm_src                 000=I 001=S 010=B 011=J 100=U
//   o_alu_control             ALU op code (upper bits 0)
//   o_illegal_instr           trap indicator
//   o_state                   current FSM state (debug)
//
// Build option: define ILLEGAL_TRAP_EN to send illegal instructions to a
// TRAP state that only reset leaves. Without it an illegal instruction
// is a NOP (back to FETCH) and o_illegal_instr is tied 0.
module multicycle_control_unit #(
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [6:0]            i_opcode,
  input  logic [2:0]            i_funct3,
  input  logic                  i_funct7_5,
  input  logic                  i_alu_zero,
  input  logic                  i_alu_lt,
  input  logic                  i_alu_ltu,
  input  logic                  i_mem_ready,
  output logic                  o_pc_write,
  output logic                  o_IR_write,
  output logic                  o_reg_write,
  output logic                  o_mem_write,
  output logic                  o_mem_read,
  output logic                  o_address_src,
  output logic [1:0]            o_result_src,
  output logic [1:0]            o_alu_src_A,
  output logic [1:0]            o_alu_src_B,
  output logic [2:0]            o_imm_src,
  output logic [ALU_CTRL_W-1:0] o_alu_control,
  output logic                  o_illegal_instr,
  output logic [3:0]            o_state
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_LINK      = 4'd12,
    S_LUI       = 4'd13,
    S_AUIPC     = 4'd14
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP    = 4'd15
`endif
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_op_ok;
  logic       w_illegal;
  logic       w_br_taken;
  logic [3:0] w_alu_dec;
  logic [3:0] w_alu;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Only opcode and the two reserved branch funct3 codes are screened.
  always_comb begin
    case (i_opcode)
      OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: w_op_ok = 1'b1;
      default:                           w_op_ok = 1'b0;
    endcase
    w_illegal = !w_op_ok ||
                (i_opcode == OP_BRANCH && i_funct3[2:1] == 2'b01);
  end

  always_comb begin
    case (i_funct3)
      3'b000:  w_br_taken = i_alu_zero;
      3'b001:  w_br_taken = !i_alu_zero;
      3'b100:  w_br_taken = i_alu_lt;
      3'b101:  w_br_taken = !i_alu_lt;
      3'b110:  w_br_taken = i_alu_ltu;
      3'b111:  w_br_taken = !i_alu_ltu;
      default: w_br_taken = 1'b0;
    endcase
  end

  // funct7_5 selects sub only for R-type; srl/sra uses it in both.
  always_comb begin
    case (i_funct3)
      3'b000:  w_alu_dec = (r_state == S_EXEC_R && i_funct7_5)
                           ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_dec = ALU_SLL;
      3'b010:  w_alu_dec = ALU_SLT;
      3'b011:  w_alu_dec = ALU_SLTU;
      3'b100:  w_alu_dec = ALU_XOR;
      3'b101:  w_alu_dec = i_funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_dec = ALU_OR;
      default: w_alu_dec = ALU_AND;
    endcase
  end

  always_comb begin
    case (i_opcode)
      OP_STORE:        o_imm_src = 3'b001;
      OP_BRANCH:       o_imm_src = 3'b010;
      OP_JAL:          o_imm_src = 3'b011;
      OP_LUI, OP_AUIPC: o_imm_src = 3'b100;
      default:         o_imm_src = 3'b000;
    endcase
  end

  always_comb begin
    w_next          = r_state;
    o_pc_write      = 1'b0;
    o_IR_write      = 1'b0;
    o_reg_write     = 1'b0;
    o_mem_write     = 1'b0;
    o_mem_read      = 1'b0;
    o_address_src   = 1'b0;
    o_result_src    = 2'b00;
    o_alu_src_A     = 2'b00;
    o_alu_src_B     = 2'b00;
    w_alu           = ALU_ADD;
    o_illegal_instr = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_alu_src_B  = 2'b10;
        o_result_src = 2'b10;
        o_IR_write   = i_mem_ready;
        o_pc_write   = i_mem_ready;
        if (i_mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        o_alu_src_A = 2'b01;
        o_alu_src_B = 2'b01;
        if (w_illegal) begin
`ifdef ILLEGAL_TRAP_EN
          w_next = S_TRAP;
`else
          w_next = S_FETCH;
`endif
        end else begin
          case (i_opcode)
            OP_LOAD, OP_STORE: w_next = S_MEM_ADR;
            OP_R:              w_next = S_EXEC_R;
            OP_I:              w_next = S_EXEC_I;
            OP_BRANCH:         w_next = S_BRANCH;
            OP_JAL:            w_next = S_JAL;
            OP_JALR:           w_next = S_JALR;
            OP_LUI:            w_next = S_LUI;
            default:           w_next = S_AUIPC;
          endcase
        end
      end
      S_MEM_ADR: begin
        o_alu_src_A = 2'b10;
        o_alu_src_B = 2'b01;
        // opcode bit 5 separates store (0100011) from load (0000011)
        w_next = i_opcode[5] ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        o_address_src = 1'b1;
        o_mem_read    = 1'b1;
        if (i_mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        o_result_src = 2'b01;
        o_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEM_WRITE: begin
        o_address_src = 1'b1;
        o_mem_write   = 1'b1;
        if (i_mem_ready) w_next = S_FETCH;
      end
      S_EXEC_R: begin
        o_alu_src_A = 2'b10;
        w_alu       = w_alu_dec;
        w_next      = S_ALU_WB;
      end
      S_EXEC_I: begin
        o_alu_src_A = 2'b10;
        o_alu_src_B = 2'b01;
        w_alu       = w_alu_dec;
        w_next      = S_ALU_WB;
      end
      S_ALU_WB: begin
        o_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        o_alu_src_A = 2'b10;
        w_alu       = ALU_SUB;
        o_pc_write  = w_br_taken;
        w_next      = S_FETCH;
      end
      S_JAL: begin
        o_pc_write  = 1'b1;
        o_alu_src_A = 2'b01;
        o_alu_src_B = 2'b10;
        w_next      = S_ALU_WB;
      end
      S_JALR: begin
        o_alu_src_A  = 2'b10;
        o_alu_src_B  = 2'b01;
        o_result_src = 2'b10;
        o_pc_write   = 1'b1;
        w_next       = S_LINK;
      end
      S_LINK: begin
        o_alu_src_A = 2'b01;
        o_alu_src_B = 2'b10;
        w_next      = S_ALU_WB;
      end
      S_LUI: begin
        o_alu_src_A = 2'b11;
        o_alu_src_B = 2'b01;
        w_next      = S_ALU_WB;
      end
      S_AUIPC: begin
        o_alu_src_A = 2'b01;
        o_alu_src_B = 2'b01;
        w_next      = S_ALU_WB;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        o_illegal_instr = 1'b1;
        w_next          = S_TRAP;
      end
`endif
      default: w_next = S_FETCH;
    endcase
    // Reset overrides the mem_ready-driven FETCH enables as well.
    if (i_rst) begin
      o_pc_write      = 1'b0;
      o_IR_write      = 1'b0;
      o_reg_write     = 1'b0;
      o_mem_write     = 1'b0;
      o_mem_read      = 1'b0;
      o_illegal_instr = 1'b0;
    end
  end

  always_comb begin
    o_alu_control      = '0;
    o_alu_control[3:0] = w_alu;
  end

  assign o_state = r_state;

endmodule
